orb_packer_gen: RTL and testbench
=================================

# orb_packer_gen

Parametrised successor of the orbital word packer. It takes one byte per strobe from the telemetry byte source and formats each data slot into an orbital word. It writes that word into the frame RAM at a computed stride address, skipping the service slots of each packet. It adds configurable widths, strides, packet and page counts, optional odd/even page interleave driven by SW, a first-slot marker bit and packet/wrap status pulses.

## Interface
Parameters:
- DATA_W, 8: input byte width.
- WORD_W, 12: output word width; must be ≥ DATA_W+1.
- SLOTS, 16: data slots (written strobes) per packet.
- FRAME, 20: total strobes per packet; must be > SLOTS.
- ADDR_W, 11: RAM address width.
- SLOT_STRIDE, 2: address step between slots.
- PACK_STRIDE, 32: address step between packets.
- PACKS, 64: packets before the packet counter wraps.
- WE_DLY, 28: cycles from capture to WE rise; must be ≥ 2.
- WE_HOLD, 32: cycles from capture to WAIT entry; must be > WE_DLY.
- IL_EN, 1: 1 = add synced SW to the address LSB (page interleave).
- MARK_EN, 0: 1 = set the word MSB on slot 0 of each packet.

Ports:
- clk in 1: single clock.
- rst in 1: asynchronous, active-high reset.
- iData in DATA_W: byte. Must be stable from the synced strobe rise to capture.
- strob in 1: asynchronous byte strobe.
- SW in 1: asynchronous page select.
- orbWord out WORD_W: formatted word.
- WE out 1: RAM write enable.
- WrAddr out ADDR_W: RAM address.
- pkt_done out 1: 1-cycle pulse at the end of a packet.
- wrap out 1: 1-cycle pulse when the packet counter wraps to 0.
- sw_evt out 1: 1-cycle pulse on a synced SW change.

## Operation
- strob and SW each pass through a 2-flop synchroniser: strS and swS.
- Counters:
  - slot: 0..FRAME-1.
  - pack: 0..PACKS-1.
  - weCnt.
- States: IDLE, WESET, WAIT.

IDLE, when strS=1 (this is the capture cycle C):
- slot < SLOTS:
  - orbWord = {mark, iData, zeros(WORD_W-DATA_W-1)}.
  - mark = MARK_EN && slot==0.
  - WrAddr = slot*SLOT_STRIDE + pack*PACK_STRIDE + (IL_EN ? swS : 0), truncated to ADDR_W bits.
  - slot++, then go to WESET.
- SLOTS ≤ slot < FRAME-1: slot++, go to WAIT. No write occurs.
- slot == FRAME-1:
  - slot = 0, pkt_done = 1, go to WAIT.
  - pack++; if pack == PACKS-1, pack = 0 instead and wrap = 1.

WESET:
- weCnt counts up from 0.
- WE = 1 at weCnt == WE_DLY-1, visible at cycle C+WE_DLY.
- At weCnt == WE_HOLD-1: weCnt = 0, go to WAIT.

WAIT:
- When strS=0: WE = 0, go to IDLE.

SW change (swS differs from its previous value):
- slot, pack and weCnt clear; sw_evt = 1.
- The state machine is not disturbed. A write already in WESET finishes with its latched WrAddr and orbWord.
- SW clear has priority over simultaneous counter increments, pkt_done and wrap (both pulses are suppressed).

## Timing
- Reset values:
  - orbWord = 0, WE = 0, WrAddr = 0.
  - pkt_done, wrap, sw_evt = 0.
  - Counters 0, state IDLE, synchronisers 0.
- Reset is asynchronous. Asserting it mid-write drops WE immediately at the register output.
- Capture latency: C falls 2–3 clk after the strob rise.
- WE timing: WE rises at C+WE_DLY. Minimum WE width is WE_HOLD-WE_DLY+1 cycles. WE falls 1 cycle after the first WAIT cycle with strS=0.
- One capture per strobe high period. The strobe must be low for ≥ 1 synced cycle before the next capture.
- orbWord and WrAddr are stable throughout WE high.
- All status outputs are registered 1-cycle pulses, aligned with the counter update.

## Test plan
1. Default parameters, iData=0xA5, 1 strobe after reset -> orbWord=0x528, WrAddr=0, WE high from C+28 until 1 cycle after strS falls.
2. 20 strobes, iData = strobe index -> 16 writes at addresses 0,2,…,30; no WE on strobes 17–20; pkt_done pulses once; 21st strobe writes at address 32.
3. 64×20 strobes -> wrap pulses once, the next write is at address 0, and the last packet's slot 15 is at address 2046 (without interleave).
4. IL_EN=1, SW toggled 0→1 between packets -> sw_evt pulse, counters cleared, next write at address 1, then 3, 5, ….
5. SW toggle in the same cycle as capture of slot 19 -> pkt_done and wrap stay 0, slot and pack are 0, the next write is at address 0+swS.
6. rst asserted while WE=1 -> WE, WrAddr and orbWord are 0 within the same cycle; after release the first strobe writes at address 0.

Source files
------------

// File: rtl/orb_packer_gen.sv
`default_nettype none
// ============================================================================
//  Module   : orb_packer_gen
//  Brief    : Orbital word packer. Captures one telemetry byte per
//             synchronised strobe, formats it into an orbital word and
//             writes it to the frame RAM at a stride address, skipping the
//             service slots of each packet. Optional page interleave from a
//             synchronised SW input, optional first-slot marker bit, and
//             packet / wrap / SW-change status pulses.
//  Revision : 1.0 - initial release
// ============================================================================
module orb_packer_gen #(
    parameter int DATA_W      = 8,
    parameter int WORD_W      = 12,
    parameter int SLOTS       = 16,
    parameter int FRAME       = 20,
    parameter int ADDR_W      = 11,
    parameter int SLOT_STRIDE = 2,
    parameter int PACK_STRIDE = 32,
    parameter int PACKS       = 64,
    parameter int WE_DLY      = 28,
    parameter int WE_HOLD     = 32,
    parameter int IL_EN       = 1,
    parameter int MARK_EN     = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] iData,
    input  logic              strob,
    input  logic              SW,
    output logic [WORD_W-1:0] orbWord,
    output logic              WE,
    output logic [ADDR_W-1:0] WrAddr,
    output logic              pkt_done,
    output logic              wrap,
    output logic              sw_evt
);

    localparam int SLOT_W = (FRAME > 1) ? $clog2(FRAME) : 1;
    localparam int PACK_W = (PACKS > 1) ? $clog2(PACKS) : 1;
    localparam int WCNT_W = (WE_HOLD > 1) ? $clog2(WE_HOLD) : 1;
    localparam int c_PAD  = WORD_W - DATA_W - 1;

    localparam logic [SLOT_W-1:0] c_SLOTS      = SLOT_W'(SLOTS);
    localparam logic [SLOT_W-1:0] c_SLOT_LAST  = SLOT_W'(FRAME - 1);
    localparam logic [PACK_W-1:0] c_PACK_LAST  = PACK_W'(PACKS - 1);
    localparam logic [WCNT_W-1:0] c_WE_DLY_M1  = WCNT_W'(WE_DLY - 1);
    localparam logic [WCNT_W-1:0] c_WE_HOLD_M1 = WCNT_W'(WE_HOLD - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WESET = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                strob_meta_q, strS_q;
    logic                sw_meta_q, swS_q, sw_last_q;
    logic [SLOT_W-1:0]   slot_q, slot_d;
    logic [PACK_W-1:0]   pack_q, pack_d;
    logic [WCNT_W-1:0]   wecnt_q, wecnt_d;
    logic [WORD_W-1:0]   word_q, word_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                we_q, we_d;
    logic                pkt_done_q, pkt_done_d;
    logic                wrap_q, wrap_d;
    logic                sw_evt_q;

    logic                w_sw_chg;
    logic                w_mark;
    logic [31:0]         w_il;

    assign w_sw_chg = swS_q ^ sw_last_q;
    assign w_mark   = (MARK_EN != 0) && (slot_q == '0);
    assign w_il     = (IL_EN != 0) ? 32'(swS_q) : 32'd0;

    // Two-flop synchronisers for the asynchronous strobe and page select.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            strob_meta_q <= 1'b0;
            strS_q       <= 1'b0;
            sw_meta_q    <= 1'b0;
            swS_q        <= 1'b0;
            sw_last_q    <= 1'b0;
        end else begin
            strob_meta_q <= strob;
            strS_q       <= strob_meta_q;
            sw_meta_q    <= SW;
            swS_q        <= sw_meta_q;
            sw_last_q    <= swS_q;
        end
    end

    // Control state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, counters and output word/address; a SW change clears the counters last so it wins.
    always_comb begin
        state_d    = state_q;
        slot_d     = slot_q;
        pack_d     = pack_q;
        wecnt_d    = wecnt_q;
        word_d     = word_q;
        addr_d     = addr_q;
        we_d       = we_q;
        pkt_done_d = 1'b0;
        wrap_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (strS_q) begin
                    if (slot_q < c_SLOTS) begin
                        word_d  = WORD_W'({w_mark, iData}) << c_PAD;
                        addr_d  = ADDR_W'(32'(slot_q) * SLOT_STRIDE
                                          + 32'(pack_q) * PACK_STRIDE + w_il);
                        slot_d  = slot_q + 1'b1;
                        wecnt_d = '0;
                        state_d = ST_WESET;
                    end else if (slot_q != c_SLOT_LAST) begin
                        slot_d  = slot_q + 1'b1;
                        state_d = ST_WAIT;
                    end else begin
                        slot_d     = '0;
                        pkt_done_d = 1'b1;
                        state_d    = ST_WAIT;
                        if (pack_q == c_PACK_LAST) begin
                            pack_d = '0;
                            wrap_d = 1'b1;
                        end else begin
                            pack_d = pack_q + 1'b1;
                        end
                    end
                end
            end
            ST_WESET: begin
                if (wecnt_q == c_WE_DLY_M1) begin
                    we_d = 1'b1;
                end
                if (wecnt_q == c_WE_HOLD_M1) begin
                    wecnt_d = '0;
                    state_d = ST_WAIT;
                end else begin
                    wecnt_d = wecnt_q + 1'b1;
                end
            end
            ST_WAIT: begin
                if (!strS_q) begin
                    we_d    = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (w_sw_chg) begin
            slot_d     = '0;
            pack_d     = '0;
            wecnt_d    = '0;
            pkt_done_d = 1'b0;
            wrap_d     = 1'b0;
        end
    end

    // Datapath and status registers; reset clears the write immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_q     <= '0;
            pack_q     <= '0;
            wecnt_q    <= '0;
            word_q     <= '0;
            addr_q     <= '0;
            we_q       <= 1'b0;
            pkt_done_q <= 1'b0;
            wrap_q     <= 1'b0;
            sw_evt_q   <= 1'b0;
        end else begin
            slot_q     <= slot_d;
            pack_q     <= pack_d;
            wecnt_q    <= wecnt_d;
            word_q     <= word_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            pkt_done_q <= pkt_done_d;
            wrap_q     <= wrap_d;
            sw_evt_q   <= w_sw_chg;
        end
    end

    assign orbWord  = word_q;
    assign WrAddr   = addr_q;
    assign WE       = we_q;
    assign pkt_done = pkt_done_q;
    assign wrap     = wrap_q;
    assign sw_evt   = sw_evt_q;

endmodule
`default_nettype wire

// File: tb/tb_orb_packer_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_orb_packer_gen
//  Brief    : Self-checking bench for orb_packer_gen with a per-strobe
//             reference model of slot/packet bookkeeping and write timing.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_orb_packer_gen;

    localparam int DATA_W      = 8;
    localparam int WORD_W      = 12;
    localparam int SLOTS       = 16;
    localparam int FRAME       = 20;
    localparam int ADDR_W      = 11;
    localparam int SLOT_STRIDE = 2;
    localparam int PACK_STRIDE = 32;
    localparam int PACKS       = 64;
    localparam int WE_DLY      = 28;
    localparam int WE_HOLD     = 32;
    localparam int IL_EN       = 1;
    localparam int MARK_EN     = 0;

    logic              clk;
    logic              rst;
    logic [DATA_W-1:0] iData;
    logic              strob;
    logic              SW;
    logic [WORD_W-1:0] orbWord;
    logic              WE;
    logic [ADDR_W-1:0] WrAddr;
    logic              pkt_done;
    logic              wrap;
    logic              sw_evt;

    int n_vec;
    int n_err;
    int m_slot;
    int m_pack;
    int m_sw;
    int wrap_total;

    orb_packer_gen #(
        .DATA_W(DATA_W), .WORD_W(WORD_W), .SLOTS(SLOTS), .FRAME(FRAME),
        .ADDR_W(ADDR_W), .SLOT_STRIDE(SLOT_STRIDE), .PACK_STRIDE(PACK_STRIDE),
        .PACKS(PACKS), .WE_DLY(WE_DLY), .WE_HOLD(WE_HOLD), .IL_EN(IL_EN),
        .MARK_EN(MARK_EN)
    ) u_dut (
        .clk(clk), .rst(rst), .iData(iData), .strob(strob), .SW(SW),
        .orbWord(orbWord), .WE(WE), .WrAddr(WrAddr), .pkt_done(pkt_done),
        .wrap(wrap), .sw_evt(sw_evt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One strobe of h cycles; optionally flips SW on the same edge as the strobe rise.
    task automatic do_strobe(input logic [DATA_W-1:0] d, input bit tog, input int h);
        bit exp_wr, exp_pd, exp_wp;
        int exp_addr, exp_word, mark, first_exp, last_exp, fall, n_end;
        int first_k, last_k, n_pd, n_wp, n_swe, unstable;
        logic [31:0] a0, w0;
        if (tog) m_sw = 1 - m_sw;
        exp_wr   = (m_slot < SLOTS);
        mark     = (MARK_EN != 0 && m_slot == 0) ? 1 : 0;
        exp_addr = (m_slot * SLOT_STRIDE + m_pack * PACK_STRIDE + (IL_EN != 0 ? m_sw : 0))
                   % (1 << ADDR_W);
        exp_word = (((mark << DATA_W) | int'(d)) << (WORD_W - DATA_W - 1)) % (1 << WORD_W);
        exp_pd = 0;
        exp_wp = 0;
        if (tog) begin
            m_slot = 0;
            m_pack = 0;
        end else if (m_slot == FRAME - 1) begin
            m_slot = 0;
            exp_pd = 1;
            if (m_pack == PACKS - 1) begin
                m_pack = 0;
                exp_wp = 1;
            end else begin
                m_pack = m_pack + 1;
            end
        end else begin
            m_slot = m_slot + 1;
        end
        // strobe rises before edge 1, capture on edge 3, WE on edge 3+WE_DLY
        first_exp = 3 + WE_DLY;
        fall      = (h + 3 > 3 + WE_HOLD + 1) ? h + 3 : 3 + WE_HOLD + 1;
        last_exp  = fall - 1;
        n_end     = exp_wr ? last_exp + 4 : h + 6;
        first_k = 0; last_k = 0; n_pd = 0; n_wp = 0; n_swe = 0; unstable = 0;
        a0 = '0; w0 = '0;
        @(negedge clk);
        iData = d;
        strob = 1'b1;
        if (tog) SW = ~SW;
        for (int k = 1; k <= n_end; k++) begin
            @(negedge clk);
            if (WE) begin
                if (first_k == 0) begin
                    first_k = k;
                    a0 = 32'(WrAddr);
                    w0 = 32'(orbWord);
                end else if (32'(WrAddr) != a0 || 32'(orbWord) != w0) begin
                    unstable = 1;
                end
                last_k = k;
            end
            if (pkt_done) n_pd++;
            if (wrap) n_wp++;
            if (sw_evt) n_swe++;
            if (k == h) strob = 1'b0;
        end
        wrap_total += n_wp;
        if (exp_wr) begin
            chk("we_rise", first_k, first_exp);
            chk("we_fall", last_k, last_exp);
            chk("wr_addr", a0, exp_addr);
            chk("orb_word", w0, exp_word);
            chk("stable", unstable, 0);
        end else begin
            chk("no_we", first_k, 0);
        end
        chk("pkt_done", n_pd, int'(exp_pd));
        chk("wrap", n_wp, int'(exp_wp));
        chk("sw_evt", n_swe, tog ? 1 : 0);
    endtask

    // SW flip with no strobe: counters clear, one sw_evt, no write.
    task automatic toggle_sw();
        int n_swe, n_we;
        n_swe = 0;
        n_we  = 0;
        m_sw   = 1 - m_sw;
        m_slot = 0;
        m_pack = 0;
        @(negedge clk);
        SW = ~SW;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (sw_evt) n_swe++;
            if (WE) n_we++;
        end
        chk("tog_sw_evt", n_swe, 1);
        chk("tog_no_we", n_we, 0);
    endtask

    function automatic int short_h();
        return int'($urandom_range(2, 6));
    endfunction

    initial begin
        n_vec = 0; n_err = 0; wrap_total = 0;
        m_slot = 0; m_pack = 0; m_sw = 0;
        rst = 1'b1; strob = 1'b0; SW = 1'b0; iData = '0;
        repeat (3) @(negedge clk);
        chk("rst_we", WE, 0);
        chk("rst_addr", WrAddr, 0);
        chk("rst_word", orbWord, 0);
        chk("rst_status", {pkt_done, wrap, sw_evt}, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // single strobe of 0xA5
        do_strobe(8'hA5, 1'b0, 5);

        // one full packet plus the first slot of the next
        toggle_sw();
        toggle_sw();
        for (int i = 0; i < FRAME + 1; i++) do_strobe(DATA_W'(i), 1'b0, (i % 3 == 0) ? 40 : short_h());

        // full wrap of the packet counter and the write after it
        toggle_sw();
        toggle_sw();
        wrap_total = 0;
        for (int i = 0; i < PACKS * FRAME; i++) do_strobe(DATA_W'($urandom), 1'b0, short_h());
        chk("wrap_total", wrap_total, 1);
        do_strobe(DATA_W'($urandom), 1'b0, short_h());

        // page interleave: finish the packet, switch page, write odd addresses
        while (m_slot != 0) do_strobe(DATA_W'($urandom), 1'b0, short_h());
        toggle_sw();
        for (int i = 0; i < 3; i++) do_strobe(DATA_W'($urandom), 1'b0, short_h());

        // SW change coinciding with the last service slot capture
        while (m_slot != FRAME - 1) do_strobe(DATA_W'($urandom), 1'b0, short_h());
        do_strobe(DATA_W'($urandom), 1'b1, short_h());
        do_strobe(DATA_W'($urandom), 1'b0, short_h());

        // randomized mix of strobe widths and SW changes
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 15) == 0) toggle_sw();
            do_strobe(DATA_W'($urandom), ($urandom_range(0, 7) == 0),
                      ($urandom_range(0, 3) == 0) ? int'($urandom_range(7, 45)) : short_h());
        end

        // asynchronous reset in the middle of a write
        if (m_sw != 0) toggle_sw();
        while (m_slot >= SLOTS) do_strobe(DATA_W'($urandom), 1'b0, short_h());
        @(negedge clk);
        iData = 8'h3C;
        strob = 1'b1;
        repeat (3 + WE_DLY + 2) @(negedge clk);
        chk("we_before_rst", WE, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_we", WE, 0);
        chk("async_rst_addr", WrAddr, 0);
        chk("async_rst_word", orbWord, 0);
        strob = 1'b0;
        m_slot = 0; m_pack = 0; m_sw = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        do_strobe(DATA_W'($urandom), 1'b0, short_h());

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
